// File: rtl/data_memory_dumper.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_dumper
// Description : Walks the data memory word by word while the pipeline is
//               halted and streams every word, MSB first, as bytes to the
//               debug-unit UART transmitter. One start pulse = one full dump,
//               terminated by a single-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_dumper #(
    parameter int N_WORDS    = 32,
    parameter int START_ADDR = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic [31:0] o_Address,
    output logic        o_MemRead,
    output logic [1:0]  o_Long,
    output logic        o_MemSign,
    input  logic [31:0] i_Read_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done
);

    // Word index width; a single-word dump still needs a 1-bit index.
    localparam int                IDX_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [31:0]       c_BASE     = 32'(START_ADDR);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_byte_cnt;
    logic [31:0]      r_shift;
    logic             r_mem_read;
    logic             r_tx_valid;
    logic             r_busy;
    logic             r_done;

    // Full-word, unsigned reads only; the address tracks the word index and
    // never runs past the last dumped word because idx stops there.
    assign o_Long     = 2'b11;
    assign o_MemSign  = 1'b0;
    assign o_Address  = c_BASE + 32'(r_idx);
    assign o_MemRead  = r_mem_read;
    assign o_tx_data  = r_shift[31:24];
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

    // Dump sequencer: state, counters, shift register and all control outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_byte_cnt <= 2'd0;
            r_shift    <= 32'd0;
            r_mem_read <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_REQ;
                        r_idx      <= '0;
                        r_mem_read <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_REQ: begin
                    // Memory registers the word at the end of this cycle.
                    r_state    <= S_CAPTURE;
                    r_mem_read <= 1'b0;
                end
                S_CAPTURE: begin
                    // Capture here only: the CPU-side mux may change the
                    // access size afterwards even though data is held.
                    r_shift    <= i_Read_data;
                    r_byte_cnt <= 2'd0;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    // Valid and data hold until the transmitter accepts.
                    if (r_tx_valid && i_tx_ready) begin
                        r_shift    <= {r_shift[23:0], 8'h00};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            if (r_idx == c_LAST_IDX) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx      <= r_idx + IDX_W'(1);
                                r_mem_read <= 1'b1;
                                r_state    <= S_REQ;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_mem_read <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_dumper
// Description : Self-checking bench for data_memory_dumper. Two instances
//               (default 32-word dump, and a 1-word dump at address 7) are
//               driven through a table of dump scenarios and compared with a
//               byte-stream model built directly from the memory contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_dumper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, ready, sel;
    wire  start0 = start & ~sel;
    wire  start1 = start & sel;

    logic [31:0] addr0, addr1, rdata0, rdata1;
    logic        rd0, rd1, sign0, sign1, valid0, valid1, busy0, busy1, done0, done1;
    logic [1:0]  long0, long1;
    logic [7:0]  data0, data1;

    data_memory_dumper #(.N_WORDS(32), .START_ADDR(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start0),
        .o_Address(addr0), .o_MemRead(rd0), .o_Long(long0), .o_MemSign(sign0),
        .i_Read_data(rdata0), .o_tx_data(data0), .o_tx_valid(valid0),
        .i_tx_ready(ready), .o_busy(busy0), .o_done(done0)
    );

    data_memory_dumper #(.N_WORDS(1), .START_ADDR(7)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1),
        .o_Address(addr1), .o_MemRead(rd1), .o_Long(long1), .o_MemSign(sign1),
        .i_Read_data(rdata1), .o_tx_data(data1), .o_tx_valid(valid1),
        .i_tx_ready(ready), .o_busy(busy1), .o_done(done1)
    );

    // Monitored view of whichever instance is under test.
    wire [31:0] m_addr  = sel ? addr1  : addr0;
    wire        m_read  = sel ? rd1    : rd0;
    wire [1:0]  m_long  = sel ? long1  : long0;
    wire        m_sign  = sel ? sign1  : sign0;
    wire [7:0]  m_data  = sel ? data1  : data0;
    wire        m_valid = sel ? valid1 : valid0;
    wire        m_busy  = sel ? busy1  : busy0;
    wire        m_done  = sel ? done1  : done0;

    function automatic logic [31:0] mem_val(input bit s, input logic [31:0] a);
        if (s) return (a == 32'd7) ? 32'hDEADBEEF : 32'h0;
        return (a == 32'd0) ? 32'h12345678 : (32'hA0B0C000 + a);
    endfunction

    // Registered-read memories; output holds while read is low.
    always @(posedge clk) begin
        if (rd0) rdata0 <= mem_val(1'b0, addr0);
        if (rd1) rdata1 <= mem_val(1'b1, addr1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1, 2: random
    function automatic logic pick_ready(input int mode, input int c);
        logic [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[3 - (c % 4)];
        return 1'($urandom_range(0, 1));
    endfunction

    typedef struct {
        bit sel;
        int mode;
        bit inject;
        int exp_bytes;
        int exp_reads;
        int exp_done_base;
    } scen_t;

    task automatic run_dump(input scen_t s, input string tag);
        logic [7:0]  got_q[$];
        logic [7:0]  exp_q[$];
        logic [31:0] v, base;
        int c, reads, acc, done_cnt, done_cyc, stalls, perr, nw, n_mm, first_mm;
        bit prev_stall;
        logic [7:0] prev_data;
        nw = s.sel ? 1 : 32;
        base = s.sel ? 32'd7 : 32'd0;
        for (int w = 0; w < nw; w++) begin
            v = mem_val(s.sel, base + 32'(w));
            for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
        end
        c = 0; reads = 0; acc = 0; done_cnt = 0; done_cyc = -1; stalls = 0; perr = 0;
        prev_stall = 1'b0; prev_data = 8'h00;
        sel = s.sel;
        start = 1'b1;
        ready = pick_ready(s.mode, 0);
        forever begin
            step();
            c++;
            start = s.inject && (c == 10 || c == 193);
            if (c > 3000) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_timeout: got no done after %0d cycles, required done", tag, c);
                break;
            end
            if (m_long !== 2'b11 || m_sign !== 1'b0) perr++;
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) perr++;
            if (done_cyc < 0) begin
                if (m_busy !== 1'b1) perr++;
            end else if (m_busy || m_valid || m_read || m_done) begin
                perr++;
            end
            if (m_read) begin
                if (acc != 4 * reads) perr++;
                if (m_addr !== base + 32'(reads)) perr++;
                reads++;
            end
            if (m_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            ready = pick_ready(s.mode, c);
            prev_stall = m_valid && !ready;
            prev_data = m_data;
            if (m_valid && ready) begin
                got_q.push_back(m_data);
                acc++;
            end
            if (m_valid && !ready) stalls++;
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        start = 1'b0;
        n_mm = 0; first_mm = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                n_mm++;
                if (first_mm < 0) first_mm = i;
            end
        if (first_mm >= 0)
            $display("  %s first byte difference at %0d: got %0h expected %0h",
                     tag, first_mm, got_q[first_mm], exp_q[first_mm]);
        chk({tag, "_byte_count"}, got_q.size(), s.exp_bytes);
        chk({tag, "_byte_content_diffs"}, n_mm, 0);
        chk({tag, "_memread_pulses"}, reads, s.exp_reads);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_done_cycle"}, done_cyc, s.exp_done_base + stalls);
        chk({tag, "_protocol_errors"}, perr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        scen_t tbl[6];
        tbl[0] = '{sel:0, mode:0, inject:0, exp_bytes:128, exp_reads:32, exp_done_base:193};
        tbl[1] = '{sel:0, mode:1, inject:0, exp_bytes:128, exp_reads:32, exp_done_base:193};
        tbl[2] = '{sel:0, mode:0, inject:1, exp_bytes:128, exp_reads:32, exp_done_base:193};
        tbl[3] = '{sel:0, mode:2, inject:0, exp_bytes:128, exp_reads:32, exp_done_base:193};
        tbl[4] = '{sel:1, mode:0, inject:0, exp_bytes:4,   exp_reads:1,  exp_done_base:7};
        tbl[5] = '{sel:1, mode:2, inject:0, exp_bytes:4,   exp_reads:1,  exp_done_base:7};

        rst = 1'b1; start = 1'b0; ready = 1'b0; sel = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_valid",   valid0 | valid1, 0);
            chk("rst_busy",    busy0 | busy1, 0);
            chk("rst_done",    done0 | done1, 0);
            chk("rst_memread", rd0 | rd1, 0);
            chk("rst_txdata",  data0 | data1, 0);
            chk("rst_long",    {long0, long1}, 4'b1111);
            chk("rst_sign",    sign0 | sign1, 0);
            chk("rst_addr0",   addr0, 32'd0);
            chk("rst_addr1",   addr1, 32'd7);
        end
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_dump(tbl[i], $sformatf("scen%0d", i));
            step();
        end

        // Reset while word 5 is stalled in SEND with an unaccepted byte.
        sel = 1'b0; ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 33; c++) step();
        ready = 1'b0;
        chk("midrst_valid_before", valid0, 1);
        step();
        chk("midrst_valid_stalled", valid0, 1);
        chk("midrst_data_stalled", data0, 8'hA0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", valid0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_addr", addr0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_memread", rd0, 0);
        step();
        run_dump(tbl[0], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
